mem_sram_responder: RTL and testbench
=====================================

Name: mem_sram_responder

Overview:
- Memory-side responder for the req/gnt/rvalid memory interface that the AXI-to-memory converter drives as initiator.
- Grants requests, performs byte-enabled writes and word reads on an internal register array, and returns one response per granted request after a fixed pipeline latency.
- Used as the terminating slave in converter testbenches and as a small scratchpad in integration.

Parameters:
- ADDR_WIDTH, 32, byte-address width of addr_i.
- DATA_WIDTH, 32, word width in bits; multiple of 8, at least 8.
- NUM_WORDS, 256, array depth; power of two, at least 2.
- LATENCY, 1, cycles from grant to rvalid; at least 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- stall_i  in  1  when high, suppresses the grant (backpressure injection).
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  ADDR_WIDTH  byte address.
- we_i  in  1  1 = write, 0 = read.
- wdata_i  in  DATA_WIDTH  write data.
- be_i  in  DATA_WIDTH/8  byte enables, bit k selects wdata_i[8k+7:8k].
- rvalid_o  out  1  response valid; no ready, so the initiator must accept it.
- rdata_o  out  DATA_WIDTH  read data; 0 for write responses.
- outstanding_o  out  $clog2(LATENCY+1)  responses currently in flight.

Behaviour:
- Reset: every array word is 0, every pipeline stage is invalid with data 0, rvalid_o = 0, rdata_o = 0, outstanding_o = 0.
- Grant:
  - gnt_o = req_i & ~stall_i, purely combinational.
  - A request is accepted in any cycle where req_i & gnt_o.
  - At most one request is accepted per cycle.
  - Accepting needs no pipeline space, because the pipeline advances every cycle.
- Index:
  - word index = addr_i[$clog2(DATA_WIDTH/8) +: $clog2(NUM_WORDS)].
  - Low byte-offset bits are ignored.
  - Address bits above the index are ignored, so addresses alias modulo NUM_WORDS.
- Write (we_i = 1):
  - At the accepting clock edge, each byte with be_i[k] = 1 is written into the array; other bytes are unchanged.
  - be_i = 0 still produces a response but modifies nothing.
- Read (we_i = 0):
  - The array word is sampled combinationally in the accepting cycle, before any same-edge update.
  - Only one access per cycle is possible, so there is no read/write collision within a cycle.
  - A read accepted the cycle after a write to the same word returns the new data.
- Response pipeline:
  - LATENCY stages of {valid, data}.
  - Stage 0 loads {1, read data or 0} on accept and {0, 0} otherwise.
  - Stage i loads stage i-1.
  - rvalid_o and rdata_o are driven from the last stage.
  - A request accepted at edge t has rvalid_o = 1 during the cycle after edge t+LATENCY-1, i.e. exactly LATENCY cycles after the grant cycle.
  - Responses return strictly in order, one per granted request.
  - rdata_o = 0 whenever rvalid_o = 0.
- Throughput: back-to-back grants produce back-to-back rvalid with no bubbles.
- outstanding_o:
  - Registered count of in-flight responses.
  - Increments on accept and decrements when a response leaves (rvalid_o = 1 this cycle).
  - Unchanged when both happen in the same cycle.
  - Never exceeds LATENCY; equals the number of valid pipeline stages.
- stall_i:
  - Affects only new grants; responses already in flight still complete.
  - req_i held high under stall is granted in the first cycle stall_i is low.
- Reset mid-operation: all in-flight responses are discarded, rvalid_o drops to 0 immediately (asynchronously), and array contents return to 0.
- No X propagation: wdata_i, be_i and addr_i are ignored when no accept occurs.

Test Plan:
- Reset then read: LATENCY = 2; read addr 0x10 -> gnt_o = 1 in cycle 0, rvalid_o = 1 with rdata_o = 0 in cycle 2, rvalid_o = 0 in cycles 1 and 3.
- Write then read with byte enables:
  - Write 0xAABBCCDD to 0x40 with be = 0xF.
  - Write 0x11223344 to 0x40 with be = 0x5.
  - Read 0x40 -> rdata_o = 0xAA22CC44.
  - Both write responses carry rdata_o = 0.
- Back-to-back with alias:
  - NUM_WORDS = 256, 32-bit data.
  - Write 0x12345678 to 0x0000_0004.
  - Next cycle, read 0x0000_0404 (aliases to index 1) -> rdata_o = 0x12345678.
  - Responses arrive on consecutive cycles with no gap.
- Stall:
  - stall_i = 1 for 3 cycles with req_i held -> gnt_o = 0 for those cycles and outstanding_o does not change.
  - The grant occurs on the 4th cycle, and the response follows LATENCY cycles later.
- Full pipeline: LATENCY = 4, 10 consecutive reads -> outstanding_o rises 1, 2, 3, 4, holds at 4, then falls to 0 after req_i drops; 10 rvalid pulses in grant order.
- Reset mid-flight: assert rst_ni = 0 with 3 responses in flight -> rvalid_o = 0 immediately; after release, a read of a previously written word returns 0 and outstanding_o = 0.

Source files
------------

// File: rtl/mem_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_sram_responder
//  Purpose  : req/gnt/rvalid memory responder with byte-enabled register array
//             and fixed-latency in-order response pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_sram_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 256,
   parameter int LATENCY    = 1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             stall_i,
   input  logic                             req_i,
   output logic                             gnt_o,
   input  logic [ADDR_WIDTH-1:0]            addr_i,
   input  logic                             we_i,
   input  logic [DATA_WIDTH-1:0]            wdata_i,
   input  logic [DATA_WIDTH/8-1:0]          be_i,
   output logic                             rvalid_o,
   output logic [DATA_WIDTH-1:0]            rdata_o,
   output logic [$clog2(LATENCY+1)-1:0]     outstanding_o
);

   localparam int c_BE_W  = DATA_WIDTH / 8;
   localparam int c_OFF_W = $clog2(c_BE_W);
   localparam int c_IDX_W = $clog2(NUM_WORDS);
   localparam int c_CNT_W = $clog2(LATENCY + 1);

   logic                  w_accept;
   logic [c_IDX_W-1:0]    w_idx;
   logic [DATA_WIDTH-1:0] w_stage0_data;
   logic                  w_unused_addr;

   logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
   logic [LATENCY-1:0]    r_vld;
   logic [DATA_WIDTH-1:0] r_dat [LATENCY];
   logic [c_CNT_W-1:0]    r_cnt;

   assign gnt_o    = req_i & ~stall_i;
   assign w_accept = req_i & gnt_o;
   // Byte offset and bits above the index are dropped, so addresses alias.
   assign w_idx         = addr_i[c_OFF_W +: c_IDX_W];
   assign w_unused_addr = ^addr_i;

   // Read samples the array before this edge's write lands.
   assign w_stage0_data = (w_accept && !we_i) ? r_mem[w_idx] : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            r_mem[w] <= '0;
         end
      end else if (w_accept && we_i) begin
         for (int k = 0; k < c_BE_W; k++) begin
            if (be_i[k]) begin
               r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_vld <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            r_dat[i] <= '0;
         end
      end else begin
         r_vld[0] <= w_accept;
         r_dat[0] <= w_stage0_data;
         for (int i = 1; i < LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_dat[i] <= r_dat[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else begin
         case ({w_accept, r_vld[LATENCY-1]})
            2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign rvalid_o      = r_vld[LATENCY-1];
   assign rdata_o       = r_dat[LATENCY-1];
   assign outstanding_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_sram_responder
//  Purpose  : Scoreboard bench driving LATENCY=2 and LATENCY=4 responders.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sram_responder;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        stall_i = 1'b0;
   logic        req_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic        we_i = 1'b0;
   logic [31:0] wdata_i = '0;
   logic [3:0]  be_i = '0;

   logic        gnt2, gnt4, rv2, rv4;
   logic [31:0] rd2, rd4;
   logic [1:0]  out2;
   logic [2:0]  out4;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t q2[$];
   exp_t q4[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   mem_sram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(256), .LATENCY(2)) u_dut2 (
      .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .req_i(req_i), .gnt_o(gnt2),
      .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
      .rvalid_o(rv2), .rdata_o(rd2), .outstanding_o(out2)
   );

   mem_sram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(256), .LATENCY(4)) u_dut4 (
      .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .req_i(req_i), .gnt_o(gnt4),
      .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
      .rvalid_o(rv4), .rdata_o(rd4), .outstanding_o(out4)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: pop expected response whenever a DUT presents rvalid.
   always @(negedge clk_i) begin
      if (rv2) begin
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL L2 unexpected rvalid rdata=%h cycle=%0d", rd2, cyc);
         end else begin
            exp_t e;
            e = q2.pop_front();
            chk("L2 rdata", rd2, e.data);
            chk("L2 response cycle", cyc, e.cyc);
         end
      end else begin
         chk("L2 rdata idle", rd2, 32'h0);
      end
   end

   always @(negedge clk_i) begin
      if (rv4) begin
         if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL L4 unexpected rvalid rdata=%h cycle=%0d", rd4, cyc);
         end else begin
            exp_t e;
            e = q4.pop_front();
            chk("L4 rdata", rd4, e.data);
            chk("L4 response cycle", cyc, e.cyc);
         end
      end else begin
         chk("L4 rdata idle", rd4, 32'h0);
      end
   end

   // One bus cycle: drive at posedge+1, check grant/outstanding at negedge.
   task automatic drive(input logic req, input logic we, input logic stall,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic exp_gnt, input logic [31:0] exp_d,
                        input int eo2, input int eo4);
      exp_t e;
      req_i = req; we_i = we; stall_i = stall; addr_i = a; wdata_i = d; be_i = be;
      @(negedge clk_i);
      chk("L2 gnt", {31'h0, gnt2}, {31'h0, exp_gnt});
      chk("L4 gnt", {31'h0, gnt4}, {31'h0, exp_gnt});
      if (eo2 >= 0) chk("L2 outstanding", {30'h0, out2}, eo2);
      if (eo4 >= 0) chk("L4 outstanding", {29'h0, out4}, eo4);
      if (exp_gnt) begin
         e.data = exp_d; e.cyc = cyc + 2; q2.push_back(e);
         e.cyc  = cyc + 4;               q4.push_back(e);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, -1, -1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      int e2[5];
      int e4[5];
      e2 = '{2, 1, 0, 0, 0};
      e4 = '{4, 3, 2, 1, 0};

      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      chk("reset L2 rvalid", {31'h0, rv2}, 32'h0);
      chk("reset L4 rvalid", {31'h0, rv4}, 32'h0);
      chk("reset L2 rdata", rd2, 32'h0);
      chk("reset L4 rdata", rd4, 32'h0);
      chk("reset L2 outstanding", {30'h0, out2}, 32'h0);
      chk("reset L4 outstanding", {29'h0, out4}, 32'h0);
      rst_ni = 1'b1;
      idle(1);

      // Read of cleared array
      drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'h0, 0, 0);
      idle(5);

      // Byte-enabled writes then read, back-to-back
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'hAABBCCDD, 4'hF, 1'b1, 32'h0, -1, -1);
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h11223344, 4'h5, 1'b1, 32'h0, -1, -1);
      drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'hAA22CC44, -1, -1);
      idle(5);

      // Write then aliased read on the next cycle
      drive(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h12345678, 4'hF, 1'b1, 32'h0, -1, -1);
      drive(1'b1, 1'b0, 1'b0, 32'h0000_0404, 32'h0, 4'h0, 1'b1, 32'h12345678, -1, -1);
      // Zero byte-enable write must leave the word untouched
      drive(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0, -1, -1);
      drive(1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b1, 32'h12345678, -1, -1);
      idle(6);

      // Stall with request held
      for (int i = 0; i < 3; i++)
         drive(1'b1, 1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 0, 0);
      drive(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 32'h12345678, 0, 0);
      idle(6);

      // Full pipeline: 10 consecutive reads, alternating words
      for (int k = 0; k < 10; k++)
         drive(1'b1, 1'b0, 1'b0, (k % 2) ? 32'h4 : 32'h40, 32'h0, 4'h0, 1'b1,
               (k % 2) ? 32'h12345678 : 32'hAA22CC44, (k < 2) ? k : 2, (k < 4) ? k : 4);
      for (int j = 0; j < 5; j++)
         drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, e2[j], e4[j]);
      idle(2);

      // Reset with responses in flight
      drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h00000055, 4'hF, 1'b1, 32'h0, -1, -1);
      idle(6);
      for (int i = 0; i < 3; i++)
         drive(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 32'h00000055, -1, -1);
      req_i = 1'b0;
      chk("L2 rvalid before reset", {31'h0, rv2}, 32'h1);
      chk("L4 outstanding before reset", {29'h0, out4}, 32'h3);
      chk("L2 outstanding before reset", {30'h0, out2}, 32'h2);
      rst_ni = 1'b0;
      q2.delete();
      q4.delete();
      #1;
      chk("L2 rvalid in reset", {31'h0, rv2}, 32'h0);
      chk("L4 rvalid in reset", {31'h0, rv4}, 32'h0);
      chk("L2 outstanding in reset", {30'h0, out2}, 32'h0);
      chk("L4 outstanding in reset", {29'h0, out4}, 32'h0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 32'h0, 0, 0);
      drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h0, 1, 1);
      idle(7);

      chk("L2 responses outstanding at end", q2.size(), 32'h0);
      chk("L4 responses outstanding at end", q4.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
